// File: rtl/rnm_ramp_stim.sv
// Real-number-model voltage ramp generator: triangle or sawtooth sweeps over NCH
// phase-offset channels, with per-step dwell, a sweep count and a start/stop/done handshake.
module rnm_ramp_stim #(
    parameter int  NCH     = 1,
    parameter int  NSTEPS  = 18,
    parameter real VMIN    = 0.0,
    parameter real VMAX    = 1.8,
    parameter int  NSWEEPS = 6,
    parameter int  PH_OFF  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    input  logic [7:0]  hold_cycles,
    output logic        busy,
    output logic        done,
    output logic [15:0] sweep_cnt,
    output logic [15:0] step_idx,
    output real         vout [NCH],
    output logic [1:0]  fsm_state
);

    // Handshake: start is accepted only in IDLE with stop low; stop wins in IDLE and RUN;
    // done is a one-cycle pulse in DONE; busy is high exactly while in RUN.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [15:0] pos_q, pos_n;
    logic [7:0]  dwell_q, dwell_n;
    logic [15:0] sweep_n;
    logic [1:0]  mode_q, mode_n;
    logic [7:0]  hold_q, hold_n;

    function automatic int period(input logic [1:0] m);
        return (m == 2'd1 || m == 2'd2) ? NSTEPS + 1 : 2 * NSTEPS;
    endfunction

    function automatic int level(input logic [1:0] m, input int pk);
        int l;
        case (m)
            2'd1:    l = pk;
            2'd2:    l = NSTEPS - pk;
            default: l = (pk <= NSTEPS) ? pk : 2 * NSTEPS - pk;
        endcase
        return l;
    endfunction

    function automatic int chan_pos(input int k, input int p, input logic [1:0] m);
        int per;
        int q;
        per = period(m);
        q   = p + (k * PH_OFF) % per;
        if (q >= per) q = q - per;
        return q;
    endfunction

    // Voltage is always derived from the integer level so endpoints are exact and nothing drifts.
    function automatic real volt(input int l);
        return VMIN + real'(l) * (VMAX - VMIN) / real'(NSTEPS);
    endfunction

    always_comb begin
        state_n = state_q;
        pos_n   = pos_q;
        dwell_n = dwell_q;
        sweep_n = sweep_cnt;
        mode_n  = mode_q;
        hold_n  = hold_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_n = RUN;
                    pos_n   = '0;
                    dwell_n = '0;
                    sweep_n = '0;
                    mode_n  = mode;
                    hold_n  = hold_cycles;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    pos_n   = '0;
                    dwell_n = '0;
                end else if (dwell_q != hold_q) begin
                    dwell_n = dwell_q + 8'd1;
                end else begin
                    dwell_n = '0;
                    if (int'(pos_q) == period(mode_q) - 1) begin
                        pos_n = '0;
                        if (sweep_cnt != 16'hFFFF) sweep_n = sweep_cnt + 16'd1;
                        if (NSWEEPS != 0 && int'(sweep_cnt) == NSWEEPS - 1) state_n = DONE;
                    end else begin
                        pos_n = pos_q + 16'd1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            dwell_q   <= '0;
            sweep_cnt <= '0;
            mode_q    <= '0;
            hold_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
            for (int k = 0; k < NCH; k++) vout[k] <= VMIN;
        end else begin
            state_q   <= state_n;
            pos_q     <= pos_n;
            dwell_q   <= dwell_n;
            sweep_cnt <= sweep_n;
            mode_q    <= mode_n;
            hold_q    <= hold_n;
            busy      <= (state_n == RUN);
            done      <= (state_n == DONE);
            step_idx  <= (state_n == RUN) ? 16'(level(mode_n, int'(pos_n))) : 16'd0;
            for (int k = 0; k < NCH; k++) begin
                vout[k] <= (state_n == RUN)
                           ? volt(level(mode_n, chan_pos(k, int'(pos_n), mode_n)))
                           : VMIN;
            end
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_rnm_ramp_stim.sv
// Directed bench for rnm_ramp_stim: four instances cover the default triangle run, saw down
// with dwell, two-channel phase offset, and free-run, plus stop/reset/start-stop corner cases.
module tb_rnm_ramp_stim;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] start = '0;
    logic [3:0] stop  = '0;
    logic [1:0] mode  = '0;
    logic [7:0] hold  = '0;

    logic        busy_a, done_a, busy_b, done_b, busy_c, done_c, busy_d, done_d;
    logic [15:0] cnt_a, idx_a, cnt_b, idx_b, cnt_c, idx_c, cnt_d, idx_d;
    logic [1:0]  st_a, st_b, st_c, st_d;
    real         vout_a [1];
    real         vout_b [1];
    real         vout_c [2];
    real         vout_d [1];

    rnm_ramp_stim u_tri (
        .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .mode(mode), .hold_cycles(hold),
        .busy(busy_a), .done(done_a), .sweep_cnt(cnt_a), .step_idx(idx_a), .vout(vout_a),
        .fsm_state(st_a)
    );

    rnm_ramp_stim #(.NSWEEPS(1)) u_saw (
        .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .mode(mode), .hold_cycles(hold),
        .busy(busy_b), .done(done_b), .sweep_cnt(cnt_b), .step_idx(idx_b), .vout(vout_b),
        .fsm_state(st_b)
    );

    rnm_ramp_stim #(.NCH(2), .PH_OFF(18), .NSWEEPS(1)) u_ph (
        .clk(clk), .rst(rst), .start(start[2]), .stop(stop[2]), .mode(mode), .hold_cycles(hold),
        .busy(busy_c), .done(done_c), .sweep_cnt(cnt_c), .step_idx(idx_c), .vout(vout_c),
        .fsm_state(st_c)
    );

    rnm_ramp_stim #(.NSWEEPS(0)) u_free (
        .clk(clk), .rst(rst), .start(start[3]), .stop(stop[3]), .mode(mode), .hold_cycles(hold),
        .busy(busy_d), .done(done_d), .sweep_cnt(cnt_d), .step_idx(idx_d), .vout(vout_d),
        .fsm_state(st_d)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input real got, input real exp);
        n_total++;
        if (got - exp > 1e-9 || exp - got > 1e-9) begin
            n_bad++;
            $display("FAIL %s: got %g expected %g", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int runs;
        int dones;
        int t;
        int lvl;

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_idx", idx_a, 0);
        check("rst_vout", vout_a[0], 0.0);
        check("rst_state", st_a, 0);

        // Default triangle: 0.0 .. 1.8 .. 0.1 in 0.1 V steps, six sweeps of 36 cycles.
        mode = 2'd0;
        hold = 8'd0;
        pulse_start(0);
        runs  = 0;
        dones = 0;
        for (int c = 0; c < 400 && busy_a; c++) begin
            t   = c % 36;
            lvl = (t <= 18) ? t : 36 - t;
            check("tri_v", vout_a[0], lvl * 0.1);
            check("tri_idx", idx_a, lvl);
            check("tri_cnt", cnt_a, c / 36);
            dones += int'(done_a);
            runs++;
            tick();
        end
        check("tri_runs", runs, 216);
        check("tri_done", done_a, 1);
        check("tri_busy_end", busy_a, 0);
        check("tri_cnt_end", cnt_a, 6);
        check("tri_v_end", vout_a[0], 0.0);
        dones += int'(done_a);
        tick();
        check("tri_done_clr", done_a, 0);
        check("tri_idle", st_a, 0);
        check("tri_dones", dones, 1);

        // Saw down with 3-cycle dwell; mode/hold changes mid-run must not matter.
        for (int c = 0; c < 57; c++) exp_q.push_back(16'(18 - c / 3));
        mode = 2'd2;
        hold = 8'd2;
        pulse_start(1);
        mode = 2'd0;
        hold = 8'd0;
        runs = 0;
        for (int c = 0; c < 200 && busy_b; c++) begin
            if (exp_q.size() > 0) begin
                lvl = int'(exp_q.pop_front());
                check("saw_idx", idx_b, lvl);
                check("saw_v", vout_b[0], lvl * 0.1);
            end
            runs++;
            tick();
        end
        check("saw_runs", runs, 57);
        check("saw_left", exp_q.size(), 0);
        check("saw_done", done_b, 1);
        check("saw_cnt", cnt_b, 1);
        check("saw_idx_end", idx_b, 0);

        // Phase offset of half a triangle period: channels are mirror images.
        pulse_start(2);
        check("ph_v0_first", vout_c[0], 0.0);
        check("ph_v1_first", vout_c[1], 1.8);
        runs = 0;
        for (int c = 0; c < 100 && busy_c; c++) begin
            check("ph_sum", vout_c[0] + vout_c[1], 1.8);
            runs++;
            tick();
        end
        check("ph_runs", runs, 36);
        check("ph_done", done_c, 1);

        // Stop at RUN cycle 10.
        pulse_start(0);
        repeat (10) tick();
        check("stop_idx_pre", idx_a, 10);
        check("stop_busy_pre", busy_a, 1);
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        check("stop_busy", busy_a, 0);
        check("stop_done", done_a, 0);
        check("stop_v", vout_a[0], 0.0);
        check("stop_cnt", cnt_a, 0);
        check("stop_idx", idx_a, 0);
        check("stop_state", st_a, 0);
        tick();
        check("stop_done_after", done_a, 0);

        // Start and stop together in IDLE.
        start[0] = 1'b1;
        stop[0]  = 1'b1;
        tick();
        check("ss_busy", busy_a, 0);
        check("ss_state", st_a, 0);
        tick();
        start[0] = 1'b0;
        stop[0]  = 1'b0;
        check("ss_busy2", busy_a, 0);

        // Reset mid-run of a saw-up run (P=19): at cycle 20 one sweep is done, pos=1.
        mode = 2'd1;
        pulse_start(0);
        repeat (20) tick();
        check("rstm_cnt_pre", cnt_a, 1);
        check("rstm_idx_pre", idx_a, 1);
        rst      = 1'b1;
        start[0] = 1'b1;
        stop[0]  = 1'b1;
        tick();
        rst      = 1'b0;
        start[0] = 1'b0;
        stop[0]  = 1'b0;
        check("rstm_busy", busy_a, 0);
        check("rstm_done", done_a, 0);
        check("rstm_cnt", cnt_a, 0);
        check("rstm_idx", idx_a, 0);
        check("rstm_v", vout_a[0], 0.0);
        check("rstm_state", st_a, 0);

        // Free-run triangle (mode 3) for 5 periods.
        mode = 2'd3;
        hold = 8'd0;
        pulse_start(3);
        dones = 0;
        for (int c = 0; c < 180; c++) begin
            if (c == 18) check("free_peak", idx_d, 18);
            dones += int'(done_d);
            tick();
        end
        check("free_cnt", cnt_d, 5);
        check("free_busy", busy_d, 1);
        check("free_idx", idx_d, 0);
        check("free_dones", dones, 0);
        stop[3] = 1'b1;
        tick();
        stop[3] = 1'b0;
        check("free_stop_busy", busy_d, 0);
        check("free_stop_cnt", cnt_d, 5);
        check("free_stop_done", done_d, 0);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
